// File: rtl/hero_pkg.sv
// Shared definitions for the hero write bus: cycle types and the 60-bit beat format.
package hero_pkg;

   typedef enum logic [1:0] {
      HERO_IDLE  = 2'd0,
      HERO_VALID = 2'd1,
      HERO_DONE  = 2'd2,
      HERO_RSVD  = 2'd3
   } CYCLE_TYPE_E;

   typedef logic [6:0] sub_def_t;

   typedef struct packed {
      CYCLE_TYPE_E          cycle_type;
      logic [35:0]          wdat;
      sub_def_t [2:0]       another_type_reference;
      logic                 clk_en;
   } hero_write_t;

   localparam int HERO_WIDTH = 60;

endpackage

// File: rtl/hero_rx_pkg.sv
// Types local to the hero write receiver: FSM states and the buffered FIFO entry.
package hero_rx_pkg;
   import hero_pkg::*;

   typedef enum logic [1:0] {
      IDLE_S   = 2'd0,
      ACTIVE_S = 2'd1,
      DROP_S   = 2'd2
   } HERO_RX_STATE_E;

   typedef struct packed {
      logic           abort;
      logic           last;
      sub_def_t [2:0] sub;
      logic [35:0]    wdat;
   } hero_rx_entry_t;

   localparam int HERO_RX_ENTRY_T_WIDTH = 59;

endpackage

// File: rtl/hero_rx_fifo.sv
// Synchronous FIFO with registered count/full/empty; no write-to-read bypass.
module hero_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + 1'b1;
      end else if (!do_push && do_pop) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage is not reset; the consumer only sees it through the empty flag.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/hero_write_rx.sv
// Hero write bus receiver: qualifies beats, frames transactions, buffers them and
// replaces any partially delivered transaction's tail with an abort entry.
module hero_write_rx
   import hero_pkg::*;
   import hero_rx_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  hero_write_t hero_wr_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [35:0] out_wdat_o,
   output logic [20:0] out_sub_o,
   output logic        out_last_o,
   output logic        out_abort_o,
   output logic        err_ovf_o,
   output logic        err_len_o,
   input  logic        err_clr_i,
   output logic [15:0] txn_cnt_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int BC_W  = $clog2(MAX_BEATS) + 1;

   HERO_RX_STATE_E  state, state_nxt;
   logic [BC_W-1:0] beat_cnt, beat_cnt_nxt;
   logic            abort_pend, abort_nxt;
   logic            set_ovf, set_len;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
   hero_rx_entry_t   head_entry, push_entry;

   logic is_valid, is_done, beat, len_viol, has_room, may_accept;
   logic accept, abort_push, push, pop;

   assign is_valid   = hero_wr_i.clk_en && (hero_wr_i.cycle_type == HERO_VALID);
   assign is_done    = hero_wr_i.clk_en && (hero_wr_i.cycle_type == HERO_DONE);
   assign beat       = is_valid || is_done;
   assign len_viol   = is_valid && (beat_cnt == BC_W'(MAX_BEATS - 1));
   assign has_room   = fifo_count < CNT_W'(DEPTH);
   assign may_accept = !abort_pend && ((state == ACTIVE_S) || (state == IDLE_S));
   assign accept     = beat && may_accept && has_room && !len_viol;
   assign abort_push = abort_pend && !fifo_full;
   assign push       = accept || abort_push;
   assign pop        = out_valid_o && out_ready_i;

   // A drop in the middle of a delivered transaction owes the consumer an abort entry.
   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      abort_nxt    = abort_pend && !abort_push;
      set_ovf      = 1'b0;
      set_len      = 1'b0;
      case (state)
         IDLE_S: begin
            if (accept) begin
               if (is_valid) begin
                  state_nxt    = ACTIVE_S;
                  beat_cnt_nxt = BC_W'(1);
               end
            end else if (beat) begin
               set_ovf = !has_room || abort_pend;
               set_len = len_viol;
               if (is_valid) state_nxt = DROP_S;
            end
         end
         ACTIVE_S: begin
            if (accept) begin
               if (is_done) begin
                  state_nxt    = IDLE_S;
                  beat_cnt_nxt = '0;
               end else begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
            end else if (beat) begin
               set_ovf      = !has_room;
               set_len      = len_viol;
               abort_nxt    = 1'b1;
               beat_cnt_nxt = '0;
               state_nxt    = is_valid ? DROP_S : IDLE_S;
            end
         end
         DROP_S: begin
            if (is_done) state_nxt = IDLE_S;
         end
         default: state_nxt = IDLE_S;
      endcase
   end

   always_comb begin
      push_entry = '0;
      if (abort_push) begin
         push_entry.abort = 1'b1;
         push_entry.last  = 1'b1;
      end else begin
         push_entry.last = is_done;
         push_entry.sub  = hero_wr_i.another_type_reference;
         push_entry.wdat = hero_wr_i.wdat;
      end
   end

   hero_rx_fifo #(
      .WIDTH (HERO_RX_ENTRY_T_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE_S;
         beat_cnt   <= '0;
         abort_pend <= 1'b0;
         err_ovf_o  <= 1'b0;
         err_len_o  <= 1'b0;
         txn_cnt_o  <= '0;
      end else begin
         state      <= state_nxt;
         beat_cnt   <= beat_cnt_nxt;
         abort_pend <= abort_nxt;
         err_ovf_o  <= set_ovf || (err_ovf_o && !err_clr_i);
         err_len_o  <= set_len || (err_len_o && !err_clr_i);
         if (pop && head_entry.last && !head_entry.abort) begin
            txn_cnt_o <= txn_cnt_o + 16'd1;
         end
      end
   end

   // Head fields are masked while empty so the uninitialised storage never leaks out.
   assign out_valid_o = !fifo_empty;
   assign out_wdat_o  = fifo_empty ? '0 : head_entry.wdat;
   assign out_sub_o   = fifo_empty ? '0 : head_entry.sub;
   assign out_last_o  = !fifo_empty && head_entry.last;
   assign out_abort_o = !fifo_empty && head_entry.abort;

endmodule

// File: tb/tb_hero_write_rx.sv
// Self-checking bench for hero_write_rx: directed scenarios plus random traffic
// compared every cycle against a queue-based transaction model.
module tb_hero_write_rx;
   import hero_pkg::*;

   localparam int DEPTH     = 8;
   localparam int MAX_BEATS = 10;

   logic        clk;
   logic        rst_n;
   hero_write_t hero_wr;
   logic        out_valid;
   logic        out_ready;
   logic [35:0] out_wdat;
   logic [20:0] out_sub;
   logic        out_last;
   logic        out_abort;
   logic        err_ovf;
   logic        err_len;
   logic        err_clr;
   logic [15:0] txn_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit          abort;
      bit          last;
      logic [20:0] sub;
      logic [35:0] wdat;
   } exp_t;

   exp_t        q[$];
   bit          in_txn;
   bit          dropping;
   bit          abort_owed;
   int          n_beats;
   bit          m_ovf;
   bit          m_len;
   logic [15:0] m_txn;

   hero_write_rx #(
      .DEPTH     (DEPTH),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hero_wr_i   (hero_wr),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_wdat_o  (out_wdat),
      .out_sub_o   (out_sub),
      .out_last_o  (out_last),
      .out_abort_o (out_abort),
      .err_ovf_o   (err_ovf),
      .err_len_o   (err_len),
      .err_clr_i   (err_clr),
      .txn_cnt_o   (txn_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelClear();
      q.delete();
      in_txn     = 1'b0;
      dropping   = 1'b0;
      abort_owed = 1'b0;
      n_beats    = 0;
      m_ovf      = 1'b0;
      m_len      = 1'b0;
      m_txn      = '0;
   endtask

   // Transaction-level reference: what the consumer should see after this edge.
   task automatic modelStep();
      bit   was_full, owed0, is_v, is_d, ovf, len, too_long, do_push;
      exp_t e, nb;
      was_full = (q.size() >= DEPTH);
      owed0    = abort_owed;
      is_v     = hero_wr.clk_en && (hero_wr.cycle_type == HERO_VALID);
      is_d     = hero_wr.clk_en && (hero_wr.cycle_type == HERO_DONE);
      ovf      = 1'b0;
      len      = 1'b0;
      do_push  = 1'b0;
      nb.abort = 1'b0;
      nb.last  = is_d;
      nb.sub   = hero_wr.another_type_reference;
      nb.wdat  = hero_wr.wdat;
      too_long = is_v && (n_beats == MAX_BEATS - 1);
      if (owed0 && !was_full) begin
         abort_owed = 1'b0;
         do_push    = 1'b1;
         nb.abort   = 1'b1;
         nb.last    = 1'b1;
         nb.sub     = '0;
         nb.wdat    = '0;
      end
      if (is_v || is_d) begin
         if (dropping) begin
            if (is_d) dropping = 1'b0;
         end else if (in_txn) begin
            if (was_full || too_long) begin
               ovf        = was_full;
               len        = too_long;
               abort_owed = 1'b1;
               in_txn     = 1'b0;
               n_beats    = 0;
               dropping   = is_v;
            end else begin
               do_push = 1'b1;
               if (is_d) begin
                  in_txn  = 1'b0;
                  n_beats = 0;
               end else begin
                  n_beats++;
               end
            end
         end else begin
            if (was_full || owed0 || too_long) begin
               ovf      = was_full || owed0;
               len      = too_long;
               dropping = is_v;
            end else begin
               do_push = 1'b1;
               if (is_v) begin
                  in_txn  = 1'b1;
                  n_beats = 1;
               end
            end
         end
      end
      if (q.size() > 0 && out_ready) begin
         e = q.pop_front();
         if (e.last && !e.abort) m_txn = m_txn + 16'd1;
      end
      if (do_push) q.push_back(nb);
      m_ovf = ovf || (m_ovf && !err_clr);
      m_len = len || (m_len && !err_clr);
   endtask

   task automatic checkAll();
      checkOutput("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         checkOutput("out_wdat",  64'(out_wdat),  64'(q[0].wdat));
         checkOutput("out_sub",   64'(out_sub),   64'(q[0].sub));
         checkOutput("out_last",  64'(out_last),  64'(q[0].last));
         checkOutput("out_abort", 64'(out_abort), 64'(q[0].abort));
      end
      checkOutput("err_ovf", 64'(err_ovf), 64'(m_ovf));
      checkOutput("err_len", 64'(err_len), 64'(m_len));
      checkOutput("txn_cnt", 64'(txn_cnt), 64'(m_txn));
   endtask

   // Drive one cycle of inputs at the falling edge, step the model on the rising edge.
   task automatic applyStimulus(input CYCLE_TYPE_E ct, input bit en, input logic [35:0] wdat,
                                input bit ready, input bit clr);
      hero_wr.cycle_type             = ct;
      hero_wr.clk_en                 = en;
      hero_wr.wdat                   = wdat;
      hero_wr.another_type_reference = 21'($urandom);
      out_ready                      = ready;
      err_clr                        = clr;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   task automatic idleCycles(input int n, input bit ready);
      for (int i = 0; i < n; i++) applyStimulus(HERO_IDLE, 1'b1, 36'd0, ready, 1'b0);
   endtask

   task automatic asyncReset();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_ovf",   64'(err_ovf),   64'd0);
      checkOutput("rst_len",   64'(err_len),   64'd0);
      checkOutput("rst_txn",   64'(txn_cnt),   64'd0);
      modelClear();
      hero_wr   = '0;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_hold_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] r;
      rst_n     = 1'b0;
      hero_wr   = '0;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      modelClear();
      repeat (2) @(negedge clk);
      checkOutput("reset_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_wdat",  64'(out_wdat),  64'd0);
      checkOutput("reset_sub",   64'(out_sub),   64'd0);
      checkOutput("reset_last",  64'(out_last),  64'd0);
      checkOutput("reset_abort", 64'(out_abort), 64'd0);
      checkOutput("reset_txn",   64'(txn_cnt),   64'd0);
      rst_n = 1'b1;

      // Basic three-beat transaction
      applyStimulus(HERO_VALID, 1'b1, 36'd1, 1'b1, 1'b0);
      checkOutput("basic_first_visible", 64'(out_valid), 64'd1);
      applyStimulus(HERO_VALID, 1'b1, 36'd2, 1'b1, 1'b0);
      applyStimulus(HERO_DONE,  1'b1, 36'd3, 1'b1, 1'b0);
      idleCycles(3, 1'b1);
      checkOutput("basic_txn", 64'(txn_cnt), 64'd1);

      // Qualification and single-beat transaction
      applyStimulus(HERO_DONE, 1'b0, 36'hA, 1'b0, 1'b0);
      applyStimulus(HERO_DONE, 1'b1, 36'hB, 1'b0, 1'b0);
      idleCycles(2, 1'b0);
      checkOutput("single_wdat", 64'(out_wdat), 64'hB);
      checkOutput("single_last", 64'(out_last), 64'd1);
      idleCycles(3, 1'b1);
      checkOutput("single_txn", 64'(txn_cnt), 64'd2);

      // Overflow: 9 VALID + DONE into a stalled FIFO
      for (int i = 1; i <= 9; i++) applyStimulus(HERO_VALID, 1'b1, 36'(i), 1'b0, 1'b0);
      applyStimulus(HERO_DONE, 1'b1, 36'd10, 1'b0, 1'b0);
      checkOutput("ovf_flag", 64'(err_ovf), 64'd1);
      idleCycles(12, 1'b1);
      checkOutput("ovf_txn", 64'(txn_cnt), 64'd2);

      // Length limit: 10 VALID + DONE, then a clean 2-beat transaction
      for (int i = 1; i <= 10; i++) applyStimulus(HERO_VALID, 1'b1, 36'(16 + i), 1'b1, 1'b0);
      applyStimulus(HERO_DONE, 1'b1, 36'd99, 1'b1, 1'b0);
      checkOutput("len_flag", 64'(err_len), 64'd1);
      applyStimulus(HERO_VALID, 1'b1, 36'd40, 1'b1, 1'b0);
      applyStimulus(HERO_DONE,  1'b1, 36'd41, 1'b1, 1'b0);
      idleCycles(4, 1'b1);
      checkOutput("len_txn", 64'(txn_cnt), 64'd3);

      // Error clear racing a new overflow
      idleCycles(1, 1'b0);
      applyStimulus(HERO_IDLE, 1'b1, 36'd0, 1'b0, 1'b1);
      checkOutput("clr_ovf", 64'(err_ovf), 64'd0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(HERO_DONE, 1'b1, 36'(i), 1'b0, 1'b0);
      applyStimulus(HERO_DONE, 1'b1, 36'h55, 1'b0, 1'b1);
      checkOutput("clr_race_ovf", 64'(err_ovf), 64'd1);
      applyStimulus(HERO_IDLE, 1'b1, 36'd0, 1'b1, 1'b1);
      checkOutput("clr_alone_ovf", 64'(err_ovf), 64'd0);
      idleCycles(10, 1'b1);

      // Async reset mid-transaction
      applyStimulus(HERO_VALID, 1'b1, 36'd7, 1'b1, 1'b0);
      applyStimulus(HERO_VALID, 1'b1, 36'd8, 1'b0, 1'b0);
      asyncReset();
      applyStimulus(HERO_VALID, 1'b1, 36'd70, 1'b1, 1'b0);
      applyStimulus(HERO_DONE,  1'b1, 36'd71, 1'b1, 1'b0);
      idleCycles(3, 1'b1);
      checkOutput("post_rst_txn", 64'(txn_cnt), 64'd1);

      // Random traffic with varying consumer pressure
      for (int phase = 0; phase < 4; phase++) begin
         for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom()};
            applyStimulus(CYCLE_TYPE_E'($urandom_range(0, 3)),
                          $urandom_range(0, 9) < 8,
                          r[35:0],
                          $urandom_range(0, 9) < (2 + 2 * phase),
                          $urandom_range(0, 99) < 3);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
